// File: rtl/score_keeper_if.sv
// Score keeper bus: goal/new-game pulses from the ball logic toward the
// score keeper, and BCD digits, refresh strobe and winner toward the displays.
interface score_keeper_if;
    logic       point_left;
    logic       point_right;
    logic       new_game;
    logic [3:0] left_tens;
    logic [3:0] left_units;
    logic [3:0] right_tens;
    logic [3:0] right_units;
    logic       update;
    logic       game_over;
    logic [1:0] winner;

    modport master (
        output point_left, point_right, new_game,
        input  left_tens, left_units, right_tens, right_units,
        input  update, game_over, winner
    );

    modport slave (
        input  point_left, point_right, new_game,
        output left_tens, left_units, right_tens, right_units,
        output update, game_over, winner
    );
endinterface

// File: rtl/score_keeper.sv
// Pong score keeper: two-digit BCD scores per player, win detection and a
// display refresh strobe that gives each score change its own rising edge.
module score_keeper #(
    parameter int WIN_SCORE   = 11,
    parameter int UPDATE_HOLD = 4
) (
    input logic           clk,
    input logic           reset,
    score_keeper_if.slave bus
);

    typedef enum logic {PLAY, OVER} game_state_t;
    typedef enum logic [1:0] {R_IDLE, R_GAP, R_HIGH} refresh_state_t;

    localparam logic [3:0] WIN_TENS  = 4'(WIN_SCORE / 10);
    localparam logic [3:0] WIN_UNITS = 4'(WIN_SCORE % 10);
    localparam logic [3:0] HOLD_LOAD = 4'(UPDATE_HOLD - 1);

    game_state_t    game_state;
    refresh_state_t refresh_state;

    logic [3:0] left_tens_q, left_units_q, right_tens_q, right_units_q;
    logic [3:0] left_tens_nx, left_units_nx, right_tens_nx, right_units_nx;
    logic       game_over_q;
    logic [1:0] winner_q;
    logic       update_q;
    logic [3:0] hcnt;
    logic       refresh_req;
    logic       req_consumed;

    logic score_left, score_right, score_changed;
    logic left_wins, right_wins;

    // Units wrap 9 -> 0 with a carry into tens; tens never wraps since the
    // score stops at the winning value.
    function automatic logic [7:0] bcd_inc(input logic [3:0] tens, input logic [3:0] units);
        if (units == 4'd9)
            return {tens + 4'd1, 4'd0};
        else
            return {tens, units + 4'd1};
    endfunction

    assign {left_tens_nx, left_units_nx}   = bcd_inc(left_tens_q, left_units_q);
    assign {right_tens_nx, right_units_nx} = bcd_inc(right_tens_q, right_units_q);

    assign left_wins  = ({left_tens_nx, left_units_nx} == {WIN_TENS, WIN_UNITS});
    assign right_wins = ({right_tens_nx, right_units_nx} == {WIN_TENS, WIN_UNITS});

    // A simultaneous goal for both sides is ambiguous and dropped; new_game wins over goals.
    assign score_left    = !bus.new_game && (game_state == PLAY) && bus.point_left  && !bus.point_right;
    assign score_right   = !bus.new_game && (game_state == PLAY) && bus.point_right && !bus.point_left;
    assign score_changed = bus.new_game || score_left || score_right;

    // Game FSM: scores, winner and game_over all move on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            game_state    <= PLAY;
            left_tens_q   <= 4'd0;
            left_units_q  <= 4'd0;
            right_tens_q  <= 4'd0;
            right_units_q <= 4'd0;
            game_over_q   <= 1'b0;
            winner_q      <= 2'b00;
        end else if (bus.new_game) begin
            game_state    <= PLAY;
            left_tens_q   <= 4'd0;
            left_units_q  <= 4'd0;
            right_tens_q  <= 4'd0;
            right_units_q <= 4'd0;
            game_over_q   <= 1'b0;
            winner_q      <= 2'b00;
        end else if (score_left) begin
            left_tens_q  <= left_tens_nx;
            left_units_q <= left_units_nx;
            if (left_wins) begin
                game_state  <= OVER;
                game_over_q <= 1'b1;
                winner_q    <= 2'b01;
            end
        end else if (score_right) begin
            right_tens_q  <= right_tens_nx;
            right_units_q <= right_units_nx;
            if (right_wins) begin
                game_state  <= OVER;
                game_over_q <= 1'b1;
                winner_q    <= 2'b10;
            end
        end
    end

    // A pending request is taken by the refresh FSM whenever it starts a new pulse or gap.
    assign req_consumed = (refresh_state == R_GAP) ||
                          (refresh_req && (refresh_state == R_IDLE || refresh_state == R_HIGH));

    // Refresh FSM: update rises one cycle after the digits change; a change
    // during a pulse forces a one-cycle gap so the displays see a fresh edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refresh_state <= R_IDLE;
            refresh_req   <= 1'b0;
            update_q      <= 1'b0;
            hcnt          <= 4'd0;
        end else begin
            refresh_req <= score_changed || (refresh_req && !req_consumed);
            case (refresh_state)
                R_IDLE: begin
                    if (refresh_req) begin
                        refresh_state <= R_HIGH;
                        update_q      <= 1'b1;
                        hcnt          <= HOLD_LOAD;
                    end
                end
                R_HIGH: begin
                    if (refresh_req) begin
                        refresh_state <= R_GAP;
                        update_q      <= 1'b0;
                    end else if (hcnt == 4'd0) begin
                        refresh_state <= R_IDLE;
                        update_q      <= 1'b0;
                    end else begin
                        hcnt <= hcnt - 4'd1;
                    end
                end
                R_GAP: begin
                    refresh_state <= R_HIGH;
                    update_q      <= 1'b1;
                    hcnt          <= HOLD_LOAD;
                end
                default: begin
                    refresh_state <= R_IDLE;
                    update_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.left_tens   = left_tens_q;
    assign bus.left_units  = left_units_q;
    assign bus.right_tens  = right_tens_q;
    assign bus.right_units = right_units_q;
    assign bus.game_over   = game_over_q;
    assign bus.winner      = winner_q;
    assign bus.update      = update_q;

endmodule

// File: tb/tb_score_keeper.sv
// Testbench for score_keeper: directed scenarios plus random goal traffic,
// with a scoreboard that checks the digits latched on each update rising edge.
module tb_score_keeper;

    localparam int WIN = 11;

    logic clk = 1'b0;
    logic reset;

    score_keeper_if bus ();

    score_keeper #(.WIN_SCORE(WIN), .UPDATE_HOLD(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int lt;
        int lu;
        int rt;
        int ru;
        int go;
        int win;
    } exp_t;

    exp_t sb[$];
    exp_t mon_exp;
    int   vectors = 0;
    int   miscompares = 0;
    logic prev_update = 1'b0;

    int ml = 0;
    int mr = 0;
    int mover = 0;
    int mwin = 0;

    // Free-running clock.
    always #5 clk = ~clk;

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_outputs(input string tag, input int lt, input int lu, input int rt,
                                 input int ru, input int go, input int win);
        check({tag, "_left_tens"},   int'(bus.left_tens),   lt);
        check({tag, "_left_units"},  int'(bus.left_units),  lu);
        check({tag, "_right_tens"},  int'(bus.right_tens),  rt);
        check({tag, "_right_units"}, int'(bus.right_units), ru);
        check({tag, "_game_over"},   int'(bus.game_over),   go);
        check({tag, "_winner"},      int'(bus.winner),      win);
    endtask

    // Reference model: scores as plain integers, digits derived by division.
    task automatic push_expected();
        sb.push_back('{ml / 10, ml % 10, mr / 10, mr % 10, mover, mwin});
    endtask

    task automatic model_apply(input bit pl, input bit pr, input bit ng);
        if (ng) begin
            ml = 0;
            mr = 0;
            mover = 0;
            mwin = 0;
            push_expected();
        end else if (mover == 0 && (pl != pr)) begin
            if (pl) ml++;
            else    mr++;
            if (ml == WIN) begin
                mover = 1;
                mwin = 1;
            end else if (mr == WIN) begin
                mover = 1;
                mwin = 2;
            end
            push_expected();
        end
    endtask

    task automatic drive_on(input bit pl, input bit pr, input bit ng);
        bus.point_left  = pl;
        bus.point_right = pr;
        bus.new_game    = ng;
        model_apply(pl, pr, ng);
    endtask

    task automatic drive_off();
        bus.point_left  = 1'b0;
        bus.point_right = 1'b0;
        bus.new_game    = 1'b0;
    endtask

    // One-cycle pulse; returns at the negedge just after the sampling edge.
    task automatic applyStimulus(input bit pl, input bit pr, input bit ng);
        @(negedge clk);
        drive_on(pl, pr, ng);
        @(negedge clk);
        drive_off();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input int n, input bit [7:0] pattern);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("%s_update_%0d", tag, i), int'(bus.update), int'(pattern[7 - i]));
        end
    endtask

    // Monitor: every rising edge of update is a display latch; compare it
    // against the oldest outstanding expected refresh.
    always @(negedge clk) begin
        if (reset) begin
            prev_update = 1'b0;
        end else begin
            if (bus.update === 1'b1 && prev_update === 1'b0) begin
                check("refresh_expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    mon_exp = sb.pop_front();
                    check("latch_left_tens",   int'(bus.left_tens),   mon_exp.lt);
                    check("latch_left_units",  int'(bus.left_units),  mon_exp.lu);
                    check("latch_right_tens",  int'(bus.right_tens),  mon_exp.rt);
                    check("latch_right_units", int'(bus.right_units), mon_exp.ru);
                    check("latch_game_over",   int'(bus.game_over),   mon_exp.go);
                    check("latch_winner",      int'(bus.winner),      mon_exp.win);
                end
            end
            prev_update = bus.update;
        end
    end

    initial begin
        int r;
        bit [7:0] s;

        reset = 1'b1;
        drive_off();
        idle(3);
        check_outputs("reset", 0, 0, 0, 0, 0, 0);
        check("reset_update", int'(bus.update), 0);
        reset = 1'b0;
        idle(2);

        // Three left points, each giving a four-cycle update pulse.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("t1_p%0d", k), 6, 8'b1111_0000);
            idle(4);
        end
        check("t1_left_units", int'(bus.left_units), 3);
        check("t1_left_tens",  int'(bus.left_tens),  0);

        // Ten right points: carry from 9 to 10.
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            idle(6);
        end
        check("t2_right_tens",  int'(bus.right_tens),  1);
        check("t2_right_units", int'(bus.right_units), 0);

        // Left runs up to the winning score.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            if (k < 7) idle(6);
        end
        check_outputs("t3_win", 1, 1, 1, 0, 1, 1);
        idle(6);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t3_frozen", 6, 8'b0000_0000);
        check("t3_left_units", int'(bus.left_units), 1);
        check("t3_left_tens",  int'(bus.left_tens),  1);

        // Restart, then a simultaneous double goal and new_game with a goal.
        applyStimulus(1'b0, 1'b0, 1'b1);
        check_outputs("t4_newgame", 0, 0, 0, 0, 0, 0);
        idle(8);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("t4_both", 6, 8'b0000_0000);
        check_outputs("t4_both", 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        check_outputs("t4_ng_prio", 0, 0, 0, 0, 0, 0);
        idle(8);

        // Second goal two cycles after the first forces a gap in update.
        @(negedge clk);
        drive_on(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        drive_off();
        @(negedge clk);
        s[7] = bus.update;
        drive_on(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        s[6] = bus.update;
        drive_off();
        for (int i = 5; i >= 0; i--) begin
            @(negedge clk);
            s[i] = bus.update;
        end
        check("t5_update_pattern", int'(s), int'(8'b1101_1110));
        check("t5_left_units", int'(bus.left_units), 2);
        check("t5_left_tens",  int'(bus.left_tens),  0);
        idle(4);

        // Reset while update is high clears everything without a clock edge.
        applyStimulus(1'b1, 1'b0, 1'b0);
        idle(2);
        check("t6_update_before", int'(bus.update), 1);
        reset = 1'b1;
        #1;
        check("t6_update_after", int'(bus.update), 0);
        check_outputs("t6_reset", 0, 0, 0, 0, 0, 0);
        check("t6_queue_empty", sb.size(), 0);
        sb.delete();
        ml = 0;
        mr = 0;
        mover = 0;
        mwin = 0;
        idle(2);
        reset = 1'b0;
        idle(2);

        // Random traffic, at least three cycles between events.
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 99);
            if (r < 5)       applyStimulus(1'b0, 1'b0, 1'b1);
            else if (r < 12) applyStimulus(1'b1, 1'b1, 1'b0);
            else if (r < 56) applyStimulus(1'b1, 1'b0, 1'b0);
            else             applyStimulus(1'b0, 1'b1, 1'b0);
            idle($urandom_range(2, 7));
        end

        // Drain outstanding refreshes with a bounded wait.
        for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clk);
        idle(8);
        check("drain_queue_empty", sb.size(), 0);
        check_outputs("final", ml / 10, ml % 10, mr / 10, mr % 10, mover, mwin);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
